// File: rtl/signed_accumulator_pkg.sv
// Shared types and constants for the signed frame accumulator.
// Saturation vs. wrap is selected by the SIGNED_ACCUMULATOR_SATURATE_EN macro in the step adder.
package signed_accumulator_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_e;

    // Frame counter width; covers COUNT up to 2**16-1.
    localparam int unsigned CNT_W = 16;

    // Bit patterns of the signed extremes for a given width (width <= 64).
    function automatic logic [63:0] signed_max_bits(input int unsigned width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] signed_min_bits(input int unsigned width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/signed_add_ovf_step.sv
// One accumulation step: WIDTH-bit signed add with overflow detection.
// With SIGNED_ACCUMULATOR_SATURATE_EN defined the sum clamps on overflow, otherwise it wraps.
module signed_add_ovf_step
    import signed_accumulator_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] sample_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             ovf_o
);

    logic [WIDTH-1:0] wrap_sum;

`ifdef SIGNED_ACCUMULATOR_SATURATE_EN
    localparam logic [63:0]      MAX_BITS = signed_max_bits(WIDTH);
    localparam logic [63:0]      MIN_BITS = signed_min_bits(WIDTH);
    localparam logic [WIDTH-1:0] SMAX     = MAX_BITS[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SMIN     = MIN_BITS[WIDTH-1:0];
`endif

    always_comb begin
        wrap_sum = acc_i + sample_i;
        // Same-sign operands whose sum flips sign have left the representable range.
        ovf_o    = (acc_i[WIDTH-1] == sample_i[WIDTH-1]) &&
                   (wrap_sum[WIDTH-1] != acc_i[WIDTH-1]);
`ifdef SIGNED_ACCUMULATOR_SATURATE_EN
        if (ovf_o) begin
            sum_o = acc_i[WIDTH-1] ? SMIN : SMAX;
        end else begin
            sum_o = wrap_sum;
        end
`else
        sum_o = wrap_sum;
`endif
    end

endmodule

// File: rtl/signed_accumulator_with_overflow.sv
// Accumulates COUNT signed samples per frame and presents the sum with a sticky overflow flag.
// Define SIGNED_ACCUMULATOR_SATURATE_EN to clamp the running sum instead of wrapping.
module signed_accumulator_with_overflow
    import signed_accumulator_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int COUNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             up_ready,
    output logic             down_valid,
    output logic [WIDTH-1:0] down_data,
    output logic             down_overflow,
    input  logic             down_ready
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // ready/valid here depend on state only, so they never combinationally follow the peer.

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(COUNT - 1);

    acc_state_e       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] step_sum;
    logic             step_ovf;
    logic             up_fire;
    logic             down_fire;

    signed_add_ovf_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .acc_i    (acc_q),
        .sample_i (up_data),
        .sum_o    (step_sum),
        .ovf_o    (step_ovf)
    );

    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        ovf_d         = ovf_q;
        cnt_d         = cnt_q;
        up_ready      = (state_q == ACCUM);
        down_valid    = (state_q == HOLD);
        up_fire       = up_valid && up_ready;
        down_fire     = down_valid && down_ready;
        down_data     = down_valid ? acc_q : '0;
        down_overflow = down_valid && ovf_q;

        case (state_q)
            ACCUM: begin
                if (up_fire) begin
                    acc_d = step_sum;
                    ovf_d = ovf_q | step_ovf;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // Next frame starts clean; its first sample is taken no earlier than next cycle.
                if (down_fire) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_signed_accumulator_with_overflow.sv
// Randomized and directed bench for signed_accumulator_with_overflow (COUNT=4 and COUNT=1 instances).
// Honors SIGNED_ACCUMULATOR_SATURATE_EN the same way the design does.
module tb_signed_accumulator_with_overflow;

    localparam int W = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- COUNT=4 instance ----------------
    logic         up_valid, up_ready, down_valid, down_overflow, down_ready;
    logic [W-1:0] up_data, down_data;

    signed_accumulator_with_overflow #(.WIDTH(W), .COUNT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .up_valid      (up_valid),
        .up_data       (up_data),
        .up_ready      (up_ready),
        .down_valid    (down_valid),
        .down_data     (down_data),
        .down_overflow (down_overflow),
        .down_ready    (down_ready)
    );

    // ---------------- COUNT=1 instance ----------------
    logic         up_valid_1, up_ready_1, down_valid_1, down_overflow_1, down_ready_1;
    logic [W-1:0] up_data_1, down_data_1;

    signed_accumulator_with_overflow #(.WIDTH(W), .COUNT(1)) dut1 (
        .clk           (clk),
        .rst           (rst),
        .up_valid      (up_valid_1),
        .up_data       (up_data_1),
        .up_ready      (up_ready_1),
        .down_valid    (down_valid_1),
        .down_data     (down_data_1),
        .down_overflow (down_overflow_1),
        .down_ready    (down_ready_1)
    );

    // ---------------- scoreboard ----------------
    int             vectors     = 0;
    int             miscompares = 0;
    logic [W:0]     exp_q[$];   // {overflow, data} per emitted frame

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: integer running sum, range-checked after every step.
    function automatic logic [W:0] model_frame(input int samples[$]);
        int acc = 0;
        int s;
        bit ovf = 1'b0;
        int hi  = (1 << (W - 1)) - 1;
        int lo  = -(1 << (W - 1));
        foreach (samples[i]) begin
            s = acc + samples[i];
            if (s > hi || s < lo) begin
                ovf = 1'b1;
`ifdef SIGNED_ACCUMULATOR_SATURATE_EN
                s = (s > hi) ? hi : lo;
`else
                s = (s > hi) ? s - (1 << W) : s + (1 << W);
`endif
            end
            acc = s;
        end
        return {ovf, W'(acc)};
    endfunction

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic push_sample(input logic [W-1:0] x);
        int n = 0;
        up_valid = 1'b1;
        up_data  = x;
        while (!up_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check_eq("up_ready_timeout", {31'b0, up_ready}, 32'd1);
        @(negedge clk);
        up_valid = 1'b0;
        up_data  = W'($urandom);
    endtask

    task automatic send_frame(input int samples[$], input bit gaps);
        exp_q.push_back(model_frame(samples));
        foreach (samples[i]) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    up_valid = 1'b0;
                    up_data  = W'($urandom);
                    @(negedge clk);
                end
            end
            push_sample(W'(samples[i]));
            if (i < samples.size() - 1) begin
                check_eq("accum_valid", {31'b0, down_valid}, 32'd0);
                check_eq("accum_data", {28'b0, down_data}, 32'd0);
            end
        end
        // One cycle after the last accept the result must already be visible.
        check_eq("latency_valid", {31'b0, down_valid}, 32'd1);
    endtask

    task automatic send4(input int a, input int b, input int c, input int d, input bit gaps);
        int q[$];
        q.push_back(a); q.push_back(b); q.push_back(c); q.push_back(d);
        send_frame(q, gaps);
    endtask

    task automatic drain(input int stall);
        logic [W:0] exp;
        if (exp_q.size() == 0) begin
            check_eq("exp_q_empty", 32'(exp_q.size()), 32'd1);
            return;
        end
        exp = exp_q.pop_front();
        repeat (stall) begin
            down_ready = 1'b0;
            up_valid   = 1'($urandom_range(0, 1));
            up_data    = W'($urandom);
            @(negedge clk);
            check_eq("hold_valid", {31'b0, down_valid}, 32'd1);
            check_eq("hold_up_ready", {31'b0, up_ready}, 32'd0);
            check_eq("hold_data", {28'b0, down_data}, {28'b0, exp[W-1:0]});
            check_eq("hold_ovf", {31'b0, down_overflow}, {31'b0, exp[W]});
        end
        up_valid = 1'b0;
        check_eq("result_data", {28'b0, down_data}, {28'b0, exp[W-1:0]});
        check_eq("result_ovf", {31'b0, down_overflow}, {31'b0, exp[W]});
        down_ready = 1'b1;
        @(negedge clk);
        down_ready = 1'b0;
        check_eq("post_valid", {31'b0, down_valid}, 32'd0);
        check_eq("post_up_ready", {31'b0, up_ready}, 32'd1);
        check_eq("post_data", {28'b0, down_data}, 32'd0);
        check_eq("post_ovf", {31'b0, down_overflow}, 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int q[$];
        int v;
        rst          = 1'b1;
        up_valid     = 1'b0;
        up_data      = '0;
        down_ready   = 1'b0;
        up_valid_1   = 1'b0;
        up_data_1    = '0;
        down_ready_1 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_eq("reset_up_ready", {31'b0, up_ready}, 32'd1);
        check_eq("reset_valid", {31'b0, down_valid}, 32'd0);
        check_eq("reset_data", {28'b0, down_data}, 32'd0);
        check_eq("reset_ovf", {31'b0, down_overflow}, 32'd0);

        // Directed frames.
        send4(1, 2, 3, -4, 1'b0);  drain(0);
        send4(7, 1, 0, 0, 1'b0);   drain(0);
        send4(7, 1, -1, 0, 1'b0);  drain(0);

        // Backpressure: pending result held while upstream keeps offering samples.
        send4(-8, -1, 2, 3, 1'b0);
        repeat (3) begin
            down_ready = 1'b0;
            up_valid   = 1'b1;
            up_data    = 4'd5;
            @(negedge clk);
            check_eq("bp_up_ready", {31'b0, up_ready}, 32'd0);
            check_eq("bp_data", {28'b0, down_data}, {28'b0, exp_q[0][W-1:0]});
            check_eq("bp_ovf", {31'b0, down_overflow}, {31'b0, exp_q[0][W]});
        end
        drain(0);
        send4(1, 2, 3, -4, 1'b0);  drain(0);

        // Reset mid-frame discards the partial (overflowed) sum.
        push_sample(4'd5);
        push_sample(4'd5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_up_ready", {31'b0, up_ready}, 32'd1);
        check_eq("midrst_valid", {31'b0, down_valid}, 32'd0);
        send4(1, 1, 1, 1, 1'b0);   drain(0);

        // Reset while holding a result: it is never emitted.
        send4(3, 3, 3, 3, 1'b0);
        void'(exp_q.pop_back());
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("holdrst_valid", {31'b0, down_valid}, 32'd0);
        check_eq("holdrst_data", {28'b0, down_data}, 32'd0);
        send4(-2, -3, 4, 0, 1'b0); drain(0);

        // Random frames with idle gaps and downstream stalls.
        for (int f = 0; f < 25; f++) begin
            q.delete();
            for (int k = 0; k < 4; k++) begin
                v = int'($signed(W'($urandom_range(0, 15))));
                q.push_back(v);
            end
            send_frame(q, 1'b1);
            drain($urandom_range(0, 3));
        end

        // COUNT=1: continuous stream, one result every two cycles.
        q.delete();
        q.push_back(-8);
        q.push_back(7);
        for (int k = 0; k < 8; k++) q.push_back(int'($signed(W'($urandom_range(0, 15)))));
        up_valid_1   = 1'b1;
        down_ready_1 = 1'b1;
        foreach (q[i]) begin
            up_data_1 = W'(q[i]);
            check_eq("c1_up_ready", {31'b0, up_ready_1}, 32'd1);
            check_eq("c1_idle_valid", {31'b0, down_valid_1}, 32'd0);
            @(negedge clk);
            check_eq("c1_valid", {31'b0, down_valid_1}, 32'd1);
            check_eq("c1_data", {28'b0, down_data_1}, {28'b0, W'(q[i])});
            check_eq("c1_ovf", {31'b0, down_overflow_1}, 32'd0);
            up_data_1 = W'($urandom);
            @(negedge clk);
        end
        up_valid_1   = 1'b0;
        down_ready_1 = 1'b0;

        check_eq("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/signed_accumulator_with_overflow.md
SIGNED_ACCUMULATOR_WITH_OVERFLOW -- requirements
Module: signed_accumulator_with_overflow

Interface
REQ-001 Parameter WIDTH, default 4: two's-complement width of samples and accumulator.
REQ-002 Parameter COUNT, default 4: samples per frame; legal range 1..2**16-1.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 up_valid  input  1  upstream sample present.
REQ-007 up_data  input  WIDTH  signed sample, e.g. a sum from the upstream adder stage.
REQ-008 up_ready  output  1  block accepts a sample this cycle.
REQ-009 down_valid  output  1  frame result present.
REQ-010 down_data  output  WIDTH  signed frame result.
REQ-011 down_overflow  output  1  sticky overflow flag for the frame.
REQ-012 down_ready  input  1  downstream accepts the result.

Function
REQ-013 The FSM SHALL have exactly two states: ACCUM (up_ready=1, down_valid=0) and HOLD (up_ready=0, down_valid=1); both outputs are decoded from state only.
REQ-014 An upstream transfer SHALL occur only when up_valid && up_ready are high on the same edge.
REQ-015 On each transfer: acc <= step(acc, up_data); ovf <= ovf | step_ovf; cnt <= cnt + 1.
REQ-016 step_ovf SHALL be 1 iff acc and up_data have the same sign bit and the WIDTH-bit wrapped sum has the opposite sign bit.
REQ-017 The transfer with cnt == COUNT-1 SHALL move ACCUM->HOLD; down_valid rises the cycle after the last sample is accepted (latency 1).
REQ-018 In HOLD: down_data = acc and down_overflow = ovf, both held stable until the downstream transfer completes.
REQ-019 A downstream transfer (down_valid && down_ready) SHALL clear acc, ovf and cnt to 0 and move HOLD->ACCUM.
REQ-020 In HOLD, up_valid SHALL be ignored and no sample lost (up_ready=0); there is no same-cycle accept of the next frame's first sample.
REQ-021 Overflow SHALL be detected per step, not on the final result; a transient overflow keeps down_overflow=1 even if the final value is representable.
REQ-022 With COUNT=1, every accepted sample SHALL produce a result equal to that sample, with down_overflow=0.
REQ-023 down_data and down_overflow SHALL be 0 while in ACCUM.

Reset
REQ-024 When rst=1 at an edge: state=ACCUM, acc=0, ovf=0, cnt=0, down_valid=0, up_ready=1 on the next cycle; rst overrides any simultaneous handshake.
REQ-025 A reset asserted mid-frame or in HOLD SHALL discard the partial or pending result without emitting it.

Configuration
REQ-026 Macro SIGNED_ACCUMULATOR_SATURATE_EN defined: on step_ovf, acc SHALL clamp to the signed max (positive overflow) or signed min (negative overflow).
REQ-027 Macro undefined: acc SHALL wrap modulo 2**WIDTH; overflow flagging is identical in both builds.

Structure
REQ-028 Package signed_accumulator_pkg SHALL hold the state enum (ACCUM, HOLD) and the functions or constants for signed max/min of WIDTH.
REQ-029 One sub-module, signed_add_ovf_step (WIDTH-parameterised, combinational): it produces the wrapped or saturated sum and step_ovf; the top module holds the FSM and registers.

Verification
REQ-030 WIDTH=4, COUNT=4, samples 1,2,3,-4 -> down_data=2, down_overflow=0, down_valid one cycle after the 4th accept.
REQ-031 Samples 7,1,0,0 -> wrap build: down_data=-8, ovf=1; saturate build: down_data=7, ovf=1.
REQ-032 Samples 7,1,-1,0 -> wrap build: down_data=7, ovf=1 (transient overflow is sticky); saturate build: down_data=6, ovf=1.
REQ-033 Hold down_ready=0 for 3 cycles with up_valid=1 -> down_data and down_overflow stable, up_ready=0, no sample consumed; the 1,2,3,-4 frame that follows yields 2.
REQ-034 Assert rst after 2 accepted samples (5,5), then send 1,1,1,1 -> down_data=4, ovf=0, and no result emitted for the aborted frame.
REQ-035 COUNT=1 with down_ready=1 and a stream -8,7 -> results -8 then 7, ovf=0, one result every 2 cycles.
